// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the
// iterative square-root unit.
package sqrt_pkg;

  localparam int RAD_W_DEF = 16;
  localparam int ROOT_W_DEF = RAD_W_DEF / 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int root_w(input int rad_w);
    return rad_w / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration:
// trial subtract and restore select.
module sqrt_step #(
  parameter int ROOT_W = 8
) (
  input  logic [ROOT_W:0]   rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        bits,
  output logic [ROOT_W:0]   rem_nxt,
  output logic              root_bit,
  output logic              neg
);

  localparam int W = ROOT_W + 3;

  logic [W-1:0] cat;
  logic [W-1:0] sub;
  logic [W-1:0] trial;

  assign cat   = {rem, bits};
  assign sub   = W'({root, 2'b01});
  assign trial = cat - sub;

  assign neg      = trial[W-1];
  assign root_bit = ~neg;
  // restored or trial value always fits ROOT_W+1 bits
  assign rem_nxt  = (ROOT_W + 1)'(neg ? cat : trial);

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root, one root
// bit per clock, MSB first.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int RAD_W = RAD_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [RAD_W-1:0]   radicand,
  output logic [RAD_W/2-1:0] root,
  output logic [RAD_W/2:0]   remainder,
  output logic               busy,
  output logic               done
);

  localparam int ROOT_W = root_w(RAD_W);
  localparam int CNT_W =
    (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(ROOT_W - 1);

  state_t             state;
  logic [RAD_W-1:0]   sr;
  logic [CNT_W-1:0]   cnt;
  logic [ROOT_W:0]    rem_nxt;
  logic               bit_nxt;
  logic               neg;

  sqrt_step #(
    .ROOT_W (ROOT_W)
  ) u_step (
    .rem      (remainder),
    .root     (root),
    .bits     (sr[RAD_W-1 -: 2]),
    .rem_nxt  (rem_nxt),
    .root_bit (bit_nxt),
    .neg      (neg)
  );

  always_comb begin
    assert (bit_nxt == !neg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      root      <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= CALC;
            busy      <= 1'b1;
            sr        <= radicand;
            cnt       <= '0;
            root      <= '0;
            remainder <= '0;
          end
        end
        CALC: begin
          sr        <= {sr[RAD_W-3:0], 2'b00};
          root      <= ROOT_W'({root, bit_nxt});
          remainder <= rem_nxt;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sqrt_iter.md
SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 Parameter RAD_W, default 16: radicand width; even values only.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a square-root computation; accepted only in IDLE.
REQ-005 radicand  input  RAD_W  unsigned operand; captured on the edge that accepts start.
REQ-006 root  output  RAD_W/2  unsigned integer square root, floor(sqrt(radicand)).
REQ-007 remainder  output  RAD_W/2+1  radicand minus root squared.
REQ-008 busy  output  1  high while state is CALC.
REQ-009 done  output  1  single-cycle pulse marking that root and remainder are valid.

Function
REQ-010 The algorithm SHALL be restoring, one root bit per clock, MSB first, for RAD_W/2 iterations.
REQ-011 Each iteration SHALL compute the trial value: trial = {rem, next two radicand bits} - {root, 2'b01}.
- Width: RAD_W/2+3 bits, two's complement.
REQ-012 If the trial sign bit is 0, the next rem SHALL be trial and the next root SHALL be {root, 1}.
REQ-013 If the trial sign bit is 1, the next rem SHALL be {rem, next two bits} and the next root SHALL be {root, 0}.
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
- IDLE -> CALC on start=1.
- CALC -> DONE after iteration RAD_W/2-1 (counter value RAD_W/2-1).
- DONE -> IDLE unconditionally.
REQ-015 On the edge accepting start, the block SHALL:
- load the radicand shift register;
- clear rem, root and the iteration counter to 0.
REQ-016 Edges 1..RAD_W/2 after acceptance SHALL each perform one iteration.
- done SHALL be 1 for exactly the cycle following edge RAD_W/2 (8 edges for RAD_W=16).
REQ-017 start SHALL be ignored in CALC and DONE; the captured radicand SHALL NOT change.
REQ-018 Back-to-back throughput: one result per RAD_W/2+2 cycles.
- A start held high continuously SHALL be accepted again in the IDLE cycle that follows DONE.
REQ-019 root and remainder SHALL hold their final values from DONE until the next accepted start.
- They SHALL NOT be guaranteed meaningful while busy=1.
REQ-020 remainder SHALL never exceed 2*root; this is guaranteed by the algorithm, not clamped.

Reset
REQ-021 With rst_n=0 at a rising edge, the block SHALL go to IDLE and clear root, remainder, the counter and the shift register.
- busy and done SHALL be 0 from that edge onward.
REQ-022 Reset during CALC or DONE SHALL abort the computation; no done pulse SHALL follow.
REQ-023 start SHALL be ignored on any edge where rst_n=0.

Structure
REQ-024 Package sqrt_pkg SHALL hold:
- the state enum (IDLE, CALC, DONE);
- default RAD_W;
- a localparam derivation for ROOT_W = RAD_W/2.
REQ-025 One combinational sub-module, sqrt_step, SHALL implement a single iteration.
- Inputs: rem, root, two radicand bits.
- Outputs: next rem, next root bit, trial sign.
- It SHALL be instantiated once, inside sqrt_iter.

Verification
REQ-026 radicand=0, start pulse -> done 8 edges later with root=0, remainder=0.
REQ-027 radicand=65535 -> root=255, remainder=510.
REQ-028 radicand=144 -> root=12, remainder=0; then radicand=150 -> root=12, remainder=6.
REQ-029 start=1 with radicand=100, then start=1 with radicand=9 during CALC -> single done, root=10, remainder=0; outputs unchanged until the next accepted start.
REQ-030 rst_n=0 at the 4th CALC edge -> busy=0 on the next cycle, no done pulse, root=0, remainder=0; a fresh start with radicand=49 -> root=7, remainder=0.
REQ-031 start held high, radicand=2 -> done pulses every 10 cycles, each with root=1, remainder=1.
